// File: rtl/dense_layer_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// dense_layer_scheduler_pkg: shared state encoding, control decode, arbiter helper
// Rev 1.0 - initial release
// ============================================================================
package dense_layer_scheduler_pkg;

  localparam int c_RD_LATENCY = 1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ENG_RESET = 3'd1,
    ST_RUN       = 3'd2,
    ST_READOUT   = 3'd3,
    ST_FINISHED  = 3'd4,
    ST_ERROR     = 3'd5
  } state_t;

  typedef struct packed {
    logic engine_reset;
    logic en_read;
    logic en_op;
    logic busy;
    logic done;
    logic error;
  } ctrl_t;

  // Control outputs are a pure function of the state being entered.
  function automatic ctrl_t ctrl_decode(input state_t st);
    ctrl_t c;
    c = '0;
    case (st)
      ST_IDLE:      c.engine_reset = 1'b1;
      ST_ENG_RESET: begin c.engine_reset = 1'b1; c.busy = 1'b1; end
      ST_RUN:       begin c.en_read = 1'b1; c.en_op = 1'b1; c.busy = 1'b1; end
      ST_READOUT:   c.busy = 1'b1;
      ST_FINISHED:  c.done = 1'b1;
      ST_ERROR:     begin c.engine_reset = 1'b1; c.error = 1'b1; end
      default:      c.engine_reset = 1'b1;
    endcase
    return c;
  endfunction

  // A wins unless only B is eligible, or both are and B holds priority.
  function automatic logic arb_pick_a(input logic ok_a, input logic ok_b, input logic prio_b);
    return ok_a && (!ok_b || !prio_b);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dense_layer_scheduler_if.sv
`default_nettype none
// ============================================================================
// dense_layer_scheduler_if: two-reader output-BRAM read bus
// Rev 1.0 - initial release
// ============================================================================
interface dense_layer_scheduler_if #(
  parameter int ADDR_W = 7
);
  logic              rd_req_a;
  logic              rd_req_b;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic              grant_a;
  logic              grant_b;
  logic              rd_valid_a;
  logic              rd_valid_b;

  modport master (
    output rd_req_a, rd_req_b, rd_addr_a, rd_addr_b,
    input  grant_a, grant_b, rd_valid_a, rd_valid_b
  );

  modport slave (
    input  rd_req_a, rd_req_b, rd_addr_a, rd_addr_b,
    output grant_a, grant_b, rd_valid_a, rd_valid_b
  );
endinterface
`default_nettype wire

// File: rtl/dense_layer_scheduler_rr_read_arbiter.sv
`default_nettype none
// ============================================================================
// rr_read_arbiter: 2-way round-robin read arbiter, range check, valid pipeline
// Rev 1.0 - initial release
// ============================================================================
module rr_read_arbiter
  import dense_layer_scheduler_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int NEURON = 100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_active,
  input  logic              i_req_a,
  input  logic [ADDR_W-1:0] i_addr_a,
  input  logic              i_req_b,
  input  logic [ADDR_W-1:0] i_addr_b,
  output logic              o_grant_a,
  output logic              o_grant_b,
  output logic [ADDR_W-1:0] o_out_addr,
  output logic              o_out_enable,
  output logic              o_valid_a,
  output logic              o_valid_b
);

  localparam logic [31:0] c_NEURON = 32'(NEURON);

  logic              w_ok_a;
  logic              w_ok_b;
  logic              w_any;
  logic              w_pick_a;
  logic              w_valid_a;
  logic              w_valid_b;
  logic              r_prio_b;
  logic              r_grant_a;
  logic              r_grant_b;
  logic              r_out_en;
  logic [ADDR_W-1:0] r_out_addr;

  always_comb begin
    w_ok_a   = i_active && i_req_a && (32'(i_addr_a) < c_NEURON);
    w_ok_b   = i_active && i_req_b && (32'(i_addr_b) < c_NEURON);
    w_any    = w_ok_a || w_ok_b;
    w_pick_a = arb_pick_a(w_ok_a, w_ok_b, r_prio_b);
  end

  // r_prio_b remembers that A was granted last, handing the next tie to B.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prio_b   <= 1'b0;
      r_grant_a  <= 1'b0;
      r_grant_b  <= 1'b0;
      r_out_en   <= 1'b0;
      r_out_addr <= '0;
    end else begin
      r_grant_a <= w_any && w_pick_a;
      r_grant_b <= w_any && !w_pick_a;
      r_out_en  <= w_any;
      if (w_any) begin
        r_out_addr <= w_pick_a ? i_addr_a : i_addr_b;
        r_prio_b   <= w_pick_a;
      end
    end
  end

  generate
    if (c_RD_LATENCY == 1) begin : g_lat1
      logic r_va;
      logic r_vb;
      always_ff @(posedge clk) begin
        if (reset) begin
          r_va <= 1'b0;
          r_vb <= 1'b0;
        end else begin
          r_va <= r_grant_a;
          r_vb <= r_grant_b;
        end
      end
      assign w_valid_a = r_va;
      assign w_valid_b = r_vb;
    end else begin : g_latn
      logic [c_RD_LATENCY-1:0] r_pipe_a;
      logic [c_RD_LATENCY-1:0] r_pipe_b;
      always_ff @(posedge clk) begin
        if (reset) begin
          r_pipe_a <= '0;
          r_pipe_b <= '0;
        end else begin
          r_pipe_a <= {r_pipe_a[c_RD_LATENCY-2:0], r_grant_a};
          r_pipe_b <= {r_pipe_b[c_RD_LATENCY-2:0], r_grant_b};
        end
      end
      assign w_valid_a = r_pipe_a[c_RD_LATENCY-1];
      assign w_valid_b = r_pipe_b[c_RD_LATENCY-1];
    end
  endgenerate

  assign o_grant_a    = r_grant_a;
  assign o_grant_b    = r_grant_b;
  assign o_out_addr   = r_out_addr;
  assign o_out_enable = r_out_en;
  assign o_valid_a    = w_valid_a;
  assign o_valid_b    = w_valid_b;

endmodule
`default_nettype wire

// File: rtl/dense_layer_scheduler.sv
`default_nettype none
// ============================================================================
// dense_layer_scheduler: sequences the dense engine through layers, arbitrates readout
// Rev 1.0 - initial release
// ============================================================================
module dense_layer_scheduler
  import dense_layer_scheduler_pkg::*;
#(
  parameter int NUM_LAYERS     = 3,
  parameter int LAYER_W        = 2,
  parameter int NEURON         = 100,
  parameter int ADDR_W         = 7,
  parameter int RESET_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_start,
  input  logic                    i_engine_done,
  input  logic                    i_readout_done,
  dense_layer_scheduler_if.slave  rd_bus,
  output logic                    o_engine_reset,
  output logic                    o_engine_enable_read,
  output logic                    o_engine_enable_op,
  output logic [LAYER_W-1:0]      o_layer_sel,
  output logic [ADDR_W-1:0]       o_out_addr,
  output logic                    o_out_enable,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_error
);

  localparam int c_RST_CW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int c_WD_W   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [c_RST_CW-1:0] c_RST_LAST   = c_RST_CW'(RESET_CYCLES - 1);
  localparam logic [c_WD_W-1:0]   c_WD_LAST    = c_WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LAYER_W-1:0]  c_LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_RST_CW-1:0] r_rst_cnt;
  logic [c_RST_CW-1:0] w_rst_cnt_nxt;
  logic [c_WD_W-1:0]   r_wd;
  logic [c_WD_W-1:0]   w_wd_nxt;
  logic [LAYER_W-1:0]  r_layer;
  logic [LAYER_W-1:0]  w_layer_nxt;
  ctrl_t               r_ctrl;
  logic                w_arb_active;

  always_comb begin
    w_state_nxt   = r_state;
    w_rst_cnt_nxt = r_rst_cnt;
    w_wd_nxt      = r_wd;
    w_layer_nxt   = r_layer;
    case (r_state)
      ST_IDLE, ST_FINISHED, ST_ERROR: begin
        if (i_start) begin
          w_state_nxt   = ST_ENG_RESET;
          w_layer_nxt   = '0;
          w_rst_cnt_nxt = '0;
        end
      end
      ST_ENG_RESET: begin
        if (r_rst_cnt == c_RST_LAST) begin
          w_state_nxt = ST_RUN;
          w_wd_nxt    = '0;
        end else begin
          w_rst_cnt_nxt = r_rst_cnt + c_RST_CW'(1);
        end
      end
      ST_RUN: begin
        // A done arriving on the watchdog's final cycle still counts as success.
        if (i_engine_done) begin
          w_state_nxt = ST_READOUT;
          w_wd_nxt    = '0;
        end else if (r_wd == c_WD_LAST) begin
          w_state_nxt = ST_ERROR;
          w_wd_nxt    = '0;
        end else begin
          w_wd_nxt = r_wd + c_WD_W'(1);
        end
      end
      ST_READOUT: begin
        if (i_readout_done) begin
          if (r_layer < c_LAST_LAYER) begin
            w_state_nxt   = ST_ENG_RESET;
            w_layer_nxt   = r_layer + LAYER_W'(1);
            w_rst_cnt_nxt = '0;
          end else begin
            w_state_nxt = ST_FINISHED;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_rst_cnt <= '0;
      r_wd      <= '0;
      r_layer   <= '0;
      r_ctrl    <= ctrl_decode(ST_IDLE);
    end else begin
      r_state   <= w_state_nxt;
      r_rst_cnt <= w_rst_cnt_nxt;
      r_wd      <= w_wd_nxt;
      r_layer   <= w_layer_nxt;
      r_ctrl    <= ctrl_decode(w_state_nxt);
    end
  end

  assign w_arb_active = (r_state == ST_READOUT) || (r_state == ST_FINISHED);

  rr_read_arbiter #(
    .ADDR_W (ADDR_W),
    .NEURON (NEURON)
  ) u_arb (
    .clk          (clk),
    .reset        (reset),
    .i_active     (w_arb_active),
    .i_req_a      (rd_bus.rd_req_a),
    .i_addr_a     (rd_bus.rd_addr_a),
    .i_req_b      (rd_bus.rd_req_b),
    .i_addr_b     (rd_bus.rd_addr_b),
    .o_grant_a    (rd_bus.grant_a),
    .o_grant_b    (rd_bus.grant_b),
    .o_out_addr   (o_out_addr),
    .o_out_enable (o_out_enable),
    .o_valid_a    (rd_bus.rd_valid_a),
    .o_valid_b    (rd_bus.rd_valid_b)
  );

  assign o_engine_reset       = r_ctrl.engine_reset;
  assign o_engine_enable_read = r_ctrl.en_read;
  assign o_engine_enable_op   = r_ctrl.en_op;
  assign o_busy               = r_ctrl.busy;
  assign o_done               = r_ctrl.done;
  assign o_error              = r_ctrl.error;
  assign o_layer_sel          = r_layer;

endmodule
`default_nettype wire

// File: tb/tb_dense_layer_scheduler.sv
`default_nettype none
// ============================================================================
// tb_dense_layer_scheduler: layer sequencing, watchdog, reset and read-arbiter scoreboard
// Rev 1.0 - initial release
// ============================================================================
module tb_dense_layer_scheduler;

  localparam int NUM_LAYERS     = 3;
  localparam int LAYER_W        = 2;
  localparam int NEURON         = 100;
  localparam int ADDR_W         = 7;
  localparam int RESET_CYCLES   = 2;
  localparam int TIMEOUT_CYCLES = 20;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               i_start = 1'b0;
  logic               i_engine_done = 1'b0;
  logic               i_readout_done = 1'b0;
  logic               o_engine_reset;
  logic               o_engine_enable_read;
  logic               o_engine_enable_op;
  logic [LAYER_W-1:0] o_layer_sel;
  logic [ADDR_W-1:0]  o_out_addr;
  logic               o_out_enable;
  logic               o_busy;
  logic               o_done;
  logic               o_error;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit              ga;
    bit              gb;
    logic [ADDR_W-1:0] addr;
    bit              en;
  } rd_exp_t;

  rd_exp_t           exp_q[$];
  bit                m_prio_b = 1'b0;
  logic [ADDR_W-1:0] m_addr = '0;
  bit                last_ga = 1'b0;
  bit                last_gb = 1'b0;

  dense_layer_scheduler_if #(.ADDR_W(ADDR_W)) u_bus ();

  dense_layer_scheduler #(
    .NUM_LAYERS     (NUM_LAYERS),
    .LAYER_W        (LAYER_W),
    .NEURON         (NEURON),
    .ADDR_W         (ADDR_W),
    .RESET_CYCLES   (RESET_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_dut (
    .clk                  (clk),
    .reset                (reset),
    .i_start              (i_start),
    .i_engine_done        (i_engine_done),
    .i_readout_done       (i_readout_done),
    .rd_bus               (u_bus.slave),
    .o_engine_reset       (o_engine_reset),
    .o_engine_enable_read (o_engine_enable_read),
    .o_engine_enable_op   (o_engine_enable_op),
    .o_layer_sel          (o_layer_sel),
    .o_out_addr           (o_out_addr),
    .o_out_enable         (o_out_enable),
    .o_busy               (o_busy),
    .o_done               (o_done),
    .o_error              (o_error)
  );

  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL global_timeout: got no finish, expected finish before 50000");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    cyc();
    i_start = 1'b0;
  endtask

  // Counts reset-pulse cycles of a layer and stops on the first RUN cycle.
  task automatic reach_run(input int layer);
    int rc;
    rc = 0;
    for (int k = 0; k < 8; k++) begin
      if (o_engine_enable_op) break;
      if (o_engine_reset && o_busy) rc++;
      cyc();
    end
    check_val("eng_rst_len", rc, RESET_CYCLES);
    check_val("run_ctrl", {o_engine_reset, o_engine_enable_read, o_engine_enable_op, o_busy}, 4'b0111);
    check_val("layer_sel", o_layer_sel, layer);
  endtask

  task automatic run_to_done(input int layer, input int run_len, input bit poke_start);
    for (int k = 1; k < run_len; k++) begin
      i_start = poke_start && (k == 4);
      cyc();
    end
    i_start = 1'b0;
    check_val("still_run", {o_engine_enable_op, o_engine_reset}, 2'b10);
    i_engine_done = 1'b1;
    cyc();
    i_engine_done = 1'b0;
    check_val("readout_ctrl", {o_engine_reset, o_engine_enable_read, o_engine_enable_op, o_busy, o_done},
              5'b00010);
    check_val("readout_layer", o_layer_sel, layer);
  endtask

  task automatic finish_readout(input int n);
    repeat (n - 1) cyc();
    i_readout_done = 1'b1;
    cyc();
    i_readout_done = 1'b0;
  endtask

  task automatic rd_check();
    rd_exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_val("grant_a", u_bus.grant_a, e.ga);
      check_val("grant_b", u_bus.grant_b, e.gb);
      check_val("out_enable", o_out_enable, e.en);
      check_val("out_addr", o_out_addr, e.addr);
      check_val("rd_valid_a", u_bus.rd_valid_a, last_ga);
      check_val("rd_valid_b", u_bus.rd_valid_b, last_gb);
      last_ga = e.ga;
      last_gb = e.gb;
    end
  endtask

  task automatic rd_step(input bit ra, input logic [ADDR_W-1:0] aa,
                         input bit rb, input logic [ADDR_W-1:0] ab, input bit active);
    rd_exp_t e;
    bit ok_a;
    bit ok_b;
    bit win_a;
    rd_check();
    u_bus.rd_req_a  = ra;
    u_bus.rd_addr_a = aa;
    u_bus.rd_req_b  = rb;
    u_bus.rd_addr_b = ab;
    ok_a  = active && ra && (int'(aa) < NEURON);
    ok_b  = active && rb && (int'(ab) < NEURON);
    win_a = ok_a && (!ok_b || !m_prio_b);
    if (ok_a || ok_b) begin
      m_addr   = win_a ? aa : ab;
      m_prio_b = win_a;
      e.ga = win_a;
      e.gb = !win_a;
      e.en = 1'b1;
    end else begin
      e.ga = 1'b0;
      e.gb = 1'b0;
      e.en = 1'b0;
    end
    e.addr = m_addr;
    exp_q.push_back(e);
    cyc();
  endtask

  task automatic rd_drain();
    rd_step(1'b0, '0, 1'b0, '0, 1'b0);
    rd_check();
  endtask

  initial begin
    u_bus.rd_req_a  = 1'b0;
    u_bus.rd_req_b  = 1'b0;
    u_bus.rd_addr_a = '0;
    u_bus.rd_addr_b = '0;
    reset = 1'b1;
    repeat (3) cyc();
    check_val("rst_ctrl", {o_engine_reset, o_engine_enable_read, o_engine_enable_op, o_busy, o_done, o_error},
              6'b100000);
    check_val("rst_bus", {o_layer_sel, o_out_addr, o_out_enable, u_bus.grant_a, u_bus.grant_b,
                          u_bus.rd_valid_a, u_bus.rd_valid_b}, 0);
    reset = 1'b0;
    cyc();

    // Three-layer sequence; layer 1 carries an ignored start and contended reads.
    pulse_start();
    for (int l = 0; l < NUM_LAYERS; l++) begin
      reach_run(l);
      run_to_done(l, 10, l == 1);
      if (l == 1) begin
        repeat (6) rd_step(1'b1, 7'd5, 1'b1, 7'd9, 1'b1);
        rd_drain();
        finish_readout(1);
      end else begin
        finish_readout(3);
      end
    end
    check_val("finished", {o_done, o_busy, o_error, o_engine_enable_op}, 4'b1000);
    check_val("final_layer", o_layer_sel, NUM_LAYERS - 1);

    // Out-of-range reader A must never win; B keeps being served.
    repeat (4) rd_step(1'b1, 7'd100, 1'b1, 7'd0, 1'b1);
    rd_drain();

    // Watchdog: engine never reports done.
    pulse_start();
    check_val("restart", {o_done, o_busy, o_engine_reset}, 3'b011);
    reach_run(0);
    repeat (TIMEOUT_CYCLES - 1) cyc();
    check_val("wd_pre", {o_error, o_engine_enable_op}, 2'b01);
    cyc();
    check_val("wd_error", {o_error, o_engine_reset, o_busy, o_engine_enable_op}, 4'b1100);
    rd_step(1'b1, 7'd5, 1'b0, 7'd0, 1'b0);
    rd_drain();
    pulse_start();
    check_val("err_clear", {o_error, o_busy}, 2'b01);
    check_val("err_layer", o_layer_sel, 0);

    // Reset in the middle of layer 1's RUN phase.
    reach_run(0);
    run_to_done(0, 3, 1'b0);
    finish_readout(1);
    reach_run(1);
    repeat (3) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    m_prio_b = 1'b0;
    m_addr   = '0;
    check_val("mid_rst_ctrl", {o_engine_reset, o_engine_enable_read, o_engine_enable_op, o_busy, o_done, o_error},
              6'b100000);
    check_val("mid_rst_layer", o_layer_sel, 0);
    check_val("mid_rst_addr", {o_out_addr, o_out_enable}, 0);
    cyc();
    check_val("idle_hold", {o_busy, o_done, o_error, o_engine_reset}, 4'b0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
